// File: rtl/bcd_rising_2d_if.sv
// Control and display bus of the two-digit BCD up-counter.
// The master drives load/run controls; the slave (counter) drives digits and flags.
interface bcd_rising_2d_if;
    logic       PE;
    logic [3:0] D_TENS;
    logic [3:0] D_ONES;
    logic       START;
    logic       PAUSE;
    logic [3:0] TENS;
    logic [3:0] ONES;
    logic       RUNNING;
    logic       TC;
    logic       CO;

    modport master (
        output PE, D_TENS, D_ONES, START, PAUSE,
        input  TENS, ONES, RUNNING, TC, CO
    );

    modport slave (
        input  PE, D_TENS, D_ONES, START, PAUSE,
        output TENS, ONES, RUNNING, TC, CO
    );
endinterface

// File: rtl/bcd_rising_2d.sv
// Two-digit BCD elapsed-time counter: counts from a loaded value up to a fixed
// limit on prescaled ticks, with IDLE/RUN/PAUSED/DONE control and carry/terminal flags.
module bcd_rising_2d #(
    parameter int CLK_DIV  = 50000000,
    parameter int MAX_TENS = 2,
    parameter int MAX_ONES = 4
) (
    input  logic           CP,
    input  logic           CR,
    bcd_rising_2d_if.slave bus
);

    localparam int              PW        = $clog2(CLK_DIV);
    localparam logic [PW-1:0]   TICK_VAL  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]   PRESC_ONE = PW'(1);
    localparam logic [7:0]      LIMIT     = {4'(MAX_TENS), 4'(MAX_ONES)};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_e;

    // A load value must be two valid BCD digits and not beyond the limit.
    function automatic logic load_ok(input logic [3:0] t, input logic [3:0] o);
        return (t <= 4'd9) && (o <= 4'd9) && ({t, o} <= LIMIT);
    endfunction

    state_e          state_q, state_d;
    logic [3:0]      tens_q, tens_d;
    logic [3:0]      ones_q, ones_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            co_q, co_d;
    logic            running_q;
    logic            tc_q;
    logic            start_s;

    // PAUSE dominates a simultaneous START.
    assign start_s = bus.START & ~bus.PAUSE;

    // Next-state, prescaler and digit update with load > pause > start > tick priority.
    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        presc_d = presc_q;
        co_d    = 1'b0;
        if (!bus.PE) begin
            if (load_ok(bus.D_TENS, bus.D_ONES)) begin
                tens_d  = bus.D_TENS;
                ones_d  = bus.D_ONES;
                presc_d = '0;
                state_d = IDLE;
            end else begin
                state_d = state_q;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    presc_d = '0;
                    if (start_s) begin
                        if ({tens_q, ones_q} == LIMIT) begin
                            state_d = DONE;
                            co_d    = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (bus.PAUSE) begin
                        state_d = PAUSED;
                    end else if (presc_q == TICK_VAL) begin
                        presc_d = '0;
                        if (ones_q == 4'd9) begin
                            ones_d = 4'd0;
                            tens_d = tens_q + 4'd1;
                        end else begin
                            ones_d = ones_q + 4'd1;
                        end
                        if ({tens_d, ones_d} == LIMIT) begin
                            state_d = DONE;
                            co_d    = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        presc_d = presc_q + PRESC_ONE;
                    end
                end
                PAUSED: begin
                    if (start_s) begin
                        state_d = RUN;
                    end else begin
                        state_d = PAUSED;
                    end
                end
                DONE: begin
                    presc_d = '0;
                    if (start_s) begin
                        tens_d  = 4'd0;
                        ones_d  = 4'd0;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, digits, prescaler and registered flags; TC lags DONE entry by one cycle.
    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            state_q   <= IDLE;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            presc_q   <= '0;
            co_q      <= 1'b0;
            running_q <= 1'b0;
            tc_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            presc_q   <= presc_d;
            co_q      <= co_d;
            running_q <= (state_d == RUN);
            tc_q      <= (state_q == DONE) && (state_d == DONE);
        end
    end

    assign bus.TENS    = tens_q;
    assign bus.ONES    = ones_q;
    assign bus.RUNNING = running_q;
    assign bus.TC      = tc_q;
    assign bus.CO      = co_q;

endmodule
